// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master whole-transaction arbiter for the memory map port.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed master-0 priority.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_re,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_re,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  s_we,
  output logic                  s_re,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  busy
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q;
  logic            sel_q;
  logic            last_grant_q;
  logic [CW-1:0]   cnt_q;

  logic                  win_sel_d;
  logic                  win_we_d;
  logic                  win_re_d;
  logic [ADDR_WIDTH-1:0] win_addr_d;
  logic [DATA_WIDTH-1:0] win_wdata_d;
  logic [DATA_WIDTH-1:0] cap_rdata_d;

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    win_sel_d = ~m0_req;
`else
    // On a tie the master that did not own the last transaction goes next.
    if (m0_req && m1_req) win_sel_d = ~last_grant_q;
    else                  win_sel_d = ~m0_req;
`endif
    win_we_d    = win_sel_d ? m1_we    : m0_we;
    win_re_d    = win_sel_d ? m1_re    : m0_re;
    win_addr_d  = win_sel_d ? m1_addr  : m0_addr;
    win_wdata_d = win_sel_d ? m1_wdata : m0_wdata;
    // s_re is already forced low for writes, so writes and no-ops return zero.
    cap_rdata_d = s_re ? s_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      m0_gnt       <= 1'b0;
      m0_done      <= 1'b0;
      m0_rdata     <= '0;
      m1_gnt       <= 1'b0;
      m1_done      <= 1'b0;
      m1_rdata     <= '0;
      s_we         <= 1'b0;
      s_re         <= 1'b0;
      s_addr       <= '0;
      s_wdata      <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q <= ACCESS;
            sel_q   <= win_sel_d;
            cnt_q   <= CW'(ACCESS_CYCLES - 1);
            m0_gnt  <= ~win_sel_d;
            m1_gnt  <= win_sel_d;
            s_we    <= win_we_d;
            s_re    <= win_re_d & ~win_we_d;
            s_addr  <= win_addr_d;
            s_wdata <= win_wdata_d;
            busy    <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            s_we    <= 1'b0;
            s_re    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            if (sel_q) begin
              m1_done  <= 1'b1;
              m1_rdata <= cap_rdata_d;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= cap_rdata_d;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          last_grant_q <= sel_q;
          m0_gnt       <= 1'b0;
          m1_gnt       <= 1'b0;
          m0_done      <= 1'b0;
          m1_done      <= 1'b0;
          busy         <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
